ssdec_scan_ctrl: RTL
====================

# ssdec_scan_ctrl

Time-multiplexing scheduler that shares one `ssdec` seven-segment decoder across `NDIG` common-cathode digits of the lock's display. It holds a double-buffered digit store, walks the digits in a fixed round-robin, and drives the decoder's `in` and `enable` inputs together with a one-hot digit select. Between digits it inserts a blanking gap to prevent ghosting, and it can blink one selected digit. The lock FSM writes digit values into a shadow bank and commits them atomically at a frame boundary.

## Interface
- `NDIG`, default 4: number of digits; must be at least 2. `IW = $clog2(NDIG)`.
- `SCAN_DIV`, default 1000: clock cycles per digit slot; must be greater than `BLANK_CYC`.
- `BLANK_CYC`, default 16: cycles at the start of each slot with all outputs dark; must be at least 1.
- `BLINK_FRAMES`, default 32: frames per blink half-period; must be at least 1.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `wr_en`, in, 1: write `wr_val`/`wr_vis` into shadow slot `wr_idx`.
- `wr_idx`, in, IW: shadow slot index. Indices of `NDIG` or above are ignored.
- `wr_val`, in, 4: hex value for the slot.
- `wr_vis`, in, 1: digit visible (1) or dark (0).
- `commit`, in, 1: request copy of shadow to active at the next frame boundary.
- `blink_en`, in, 1: enable blinking of digit `blink_idx`.
- `blink_idx`, in, IW: digit to blink.
- `dec_in`, out, 4: to `ssdec.in`.
- `dec_enable`, out, 1: to `ssdec.enable`.
- `dig_sel`, out, NDIG: one-hot digit select; all zero during blanking.
- `frame_start`, out, 1: one-cycle pulse on the first cycle of slot 0.
- `commit_pending`, out, 1: a commit is accepted but not yet applied.

## Operation
- Counters:
  - `cnt` runs 0..SCAN_DIV-1.
  - `slot` runs 0..NDIG-1 and advances when `cnt` wraps.
  - `frame_cnt` runs 0..BLINK_FRAMES-1 and advances when `slot` wraps from NDIG-1 to 0.
  - `phase` toggles when `frame_cnt` wraps.
- Two-state FSM per slot:
  - BLANK while `cnt` < BLANK_CYC: `dig_sel`=0, `dec_enable`=0, `dec_in`=0.
  - DRIVE while `cnt` ≥ BLANK_CYC: `dig_sel`=1<<slot, `dec_in`=active_val[slot], `dec_enable`=active_vis[slot] & ~(blink_en & phase & blink_idx==slot).
- The frame boundary is the cycle where `slot`=NDIG-1 and `cnt`=SCAN_DIV-1.
- Shadow writes take effect on the next edge and never disturb the active bank.
- Commit rules:
  - pending_next = (pending | commit) & ~boundary.
  - On a boundary cycle with (pending | commit), the active bank is loaded from the shadow bank's pre-edge contents.
  - A `wr_en` in the same cycle lands in the shadow only.
  - `commit` on the boundary cycle itself is applied at that boundary; `commit_pending` never rises.
  - Repeated commits while pending are merged.
- `blink_en`/`blink_idx` are sampled live each cycle, without buffering.
- Reset values:
  - Outputs: all 0.
  - Internal state: `cnt`=0, `slot`=0, `frame_cnt`=0, `phase`=0, pending=0, FSM=BLANK.
  - Both banks hold val=0 and vis=0, so the display is dark after reset.

## Timing
- All outputs are registered. Outputs for a given (`slot`, `cnt`) appear one cycle after that counter state.
- The first cycle after `rst` falls shows BLANK outputs for slot 0 with `frame_start`=1. `frame_start` then repeats every NDIG*SCAN_DIV cycles.
- Per slot: exactly BLANK_CYC dark cycles, then SCAN_DIV-BLANK_CYC drive cycles. `dig_sel` is never high for two digits, and never changes without at least BLANK_CYC zero cycles in between.
- Commit latency: committed values first show in slot 0 of the frame following the boundary. No digit of a frame mixes old and new banks.
- Blink: each digit is dark for BLINK_FRAMES frames, then lit for BLINK_FRAMES frames, starting lit after reset.
- Asynchronous `rst` mid-frame: all outputs drop to 0 immediately, both banks clear, and a pending commit is discarded.

## Test plan
Bench parameters: NDIG=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
1. Reset then run 40 cycles -> `dig_sel`=0001,0010,0100,1000 each 6 cycles after 2 zero cycles; `dec_enable`=0 throughout; `frame_start` pulses every 32 cycles.
2. Write slots 0..3 = 1,2,3,4, all visible; commit mid-frame -> `commit_pending`=1 until the boundary; next frame drives `dec_in`=1,2,3,4 with `dec_enable`=1.
3. Write slot 2 = 7 without commit -> display keeps 3 on slot 2 indefinitely; a later commit shows 7 from the next frame's slot 0.
4. Commit asserted exactly on the boundary cycle with a simultaneous write of slot 0 = 9 -> the new bank is applied without `commit_pending` rising; slot 0 shows the old shadow value, and 9 appears only after a second commit.
5. `blink_en`=1, `blink_idx`=1 -> slot 1 `dec_enable` is 1 for frames 0-1, 0 for frames 2-3, repeating, while `dig_sel` still asserts 0010; other slots are unaffected.
6. `rst` asserted during the slot 2 DRIVE window with a commit pending -> outputs go to 0 asynchronously; after release the display stays dark and `commit_pending`=0.

Source files
------------

// File: rtl/ssdec_scan_ctrl_if.sv
// ssdec_scan_ctrl_if: bundle between the lock FSM (master) and the
// display scan controller (slave).
// Master drives: wr_en, wr_idx, wr_val, wr_vis, commit, blink_en, blink_idx.
// Slave drives:  dec_in, dec_enable, dig_sel, frame_start, commit_pending.
interface ssdec_scan_ctrl_if #(
    parameter int NDIG = 4,
    parameter int IW   = $clog2(NDIG)
);
    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [3:0]      wr_val;
    logic            wr_vis;
    logic            commit;
    logic            blink_en;
    logic [IW-1:0]   blink_idx;
    logic [3:0]      dec_in;
    logic            dec_enable;
    logic [NDIG-1:0] dig_sel;
    logic            frame_start;
    logic            commit_pending;

    modport master (
        output wr_en,
        output wr_idx,
        output wr_val,
        output wr_vis,
        output commit,
        output blink_en,
        output blink_idx,
        input  dec_in,
        input  dec_enable,
        input  dig_sel,
        input  frame_start,
        input  commit_pending
    );

    modport slave (
        input  wr_en,
        input  wr_idx,
        input  wr_val,
        input  wr_vis,
        input  commit,
        input  blink_en,
        input  blink_idx,
        output dec_in,
        output dec_enable,
        output dig_sel,
        output frame_start,
        output commit_pending
    );
endinterface

// File: rtl/ssdec_scan_ctrl.sv
// ssdec_scan_ctrl: time-multiplexed scan scheduler sharing one ssdec
// decoder across NDIG digits, with double-buffered digit store and blink.
// Ports: clk, rst (async, active-high); bus (slave modport) carries the
// shadow write port, commit, blink control, decoder drive, one-hot digit
// select, frame_start pulse and commit_pending status.
module ssdec_scan_ctrl #(
    parameter int NDIG         = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic             clk,
    input  logic             rst,
    ssdec_scan_ctrl_if.slave bus
);
    localparam int IW  = $clog2(NDIG);
    localparam int IW1 = IW + 1;
    localparam int CW  = $clog2(SCAN_DIV);
    localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0]   CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0]   SLOT_LAST  = IW'(NDIG - 1);
    localparam logic [FW-1:0]   FRM_LAST   = FW'(BLINK_FRAMES - 1);
    localparam logic [IW:0]     IDX_LIM    = IW1'(NDIG);
    localparam logic [NDIG-1:0] SEL_ONE    = NDIG'(1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    // scan position
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] slot_q, slot_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic [0:0]    state_q, state_d;

    // digit banks
    logic [NDIG-1:0][3:0] shadow_val_q, shadow_val_d;
    logic [NDIG-1:0]      shadow_vis_q, shadow_vis_d;
    logic [NDIG-1:0][3:0] active_val_q, active_val_d;
    logic [NDIG-1:0]      active_vis_q, active_vis_d;
    logic                 pending_q, pending_d;

    // registered outputs
    logic [3:0]      dec_in_q, dec_in_d;
    logic            dec_en_q, dec_en_d;
    logic [NDIG-1:0] dig_sel_q, dig_sel_d;
    logic            frame_start_q, frame_start_d;

    logic cnt_wrap;
    logic slot_wrap;
    logic frm_wrap;
    logic boundary;
    logic load_active;
    logic wr_ok;
    logic blink_dark;

    always_comb begin
        cnt_wrap  = (cnt_q == CNT_LAST);
        slot_wrap = (slot_q == SLOT_LAST);
        frm_wrap  = (frame_q == FRM_LAST);
        boundary  = cnt_wrap & slot_wrap;

        cnt_d   = cnt_wrap ? '0 : cnt_q + 1'b1;
        slot_d  = slot_q;
        frame_d = frame_q;
        phase_d = phase_q;

        if (cnt_wrap) begin
            slot_d = slot_wrap ? '0 : slot_q + 1'b1;
        end
        // blink half-period ends when the frame counter wraps
        if (boundary) begin
            frame_d = frm_wrap ? '0 : frame_q + 1'b1;
            if (frm_wrap) begin
                phase_d = ~phase_q;
            end
        end
    end

    // state_q always describes the slot phase of the current cnt_q
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
            ST_DRIVE: if (cnt_wrap) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase
    end

    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_vis_d = shadow_vis_q;
        active_val_d = active_val_q;
        active_vis_d = active_vis_q;

        // a commit seen on the boundary itself is applied right there
        load_active = boundary & (pending_q | bus.commit);
        pending_d   = (pending_q | bus.commit) & ~boundary;
        wr_ok       = bus.wr_en & ({1'b0, bus.wr_idx} < IDX_LIM);

        // the copy uses pre-edge shadow; a same-cycle write lands after it
        if (load_active) begin
            active_val_d = shadow_val_q;
            active_vis_d = shadow_vis_q;
        end
        if (wr_ok) begin
            shadow_val_d[bus.wr_idx] = bus.wr_val;
            shadow_vis_d[bus.wr_idx] = bus.wr_vis;
        end
    end

    always_comb begin
        blink_dark = bus.blink_en & phase_q
                   & (bus.blink_idx == slot_q);

        dig_sel_d     = '0;
        dec_in_d      = '0;
        dec_en_d      = 1'b0;
        frame_start_d = (slot_q == '0) & (cnt_q == '0);

        if (state_q == ST_DRIVE) begin
            dig_sel_d = SEL_ONE << slot_q;
            dec_in_d  = active_val_q[slot_q];
            dec_en_d  = active_vis_q[slot_q] & ~blink_dark;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            slot_q        <= '0;
            frame_q       <= '0;
            phase_q       <= 1'b0;
            state_q       <= ST_BLANK;
            shadow_val_q  <= '0;
            shadow_vis_q  <= '0;
            active_val_q  <= '0;
            active_vis_q  <= '0;
            pending_q     <= 1'b0;
            dec_in_q      <= '0;
            dec_en_q      <= 1'b0;
            dig_sel_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            frame_q       <= frame_d;
            phase_q       <= phase_d;
            state_q       <= state_d;
            shadow_val_q  <= shadow_val_d;
            shadow_vis_q  <= shadow_vis_d;
            active_val_q  <= active_val_d;
            active_vis_q  <= active_vis_d;
            pending_q     <= pending_d;
            dec_in_q      <= dec_in_d;
            dec_en_q      <= dec_en_d;
            dig_sel_q     <= dig_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.dec_in         = dec_in_q;
    assign bus.dec_enable     = dec_en_q;
    assign bus.dig_sel        = dig_sel_q;
    assign bus.frame_start    = frame_start_q;
    assign bus.commit_pending = pending_q;
endmodule
